// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
// Resolves three hazard classes in priority order:
//   data-memory wait  >  taken branch  >  load-use.
// The stall/flush/dmem_req outputs are combinational from the FSM state and the
// current-cycle inputs, so the pipeline reacts in the same cycle a hazard appears.
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN enables the two 32-bit
// performance counters. Without it, perf_stall_cnt and perf_flush_cnt read 0.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rf_ra0,
    input  logic [4:0]  id_rf_ra1,
    input  logic        ex_rf_we,
    input  logic [4:0]  ex_rf_wa,
    input  logic [1:0]  ex_rf_wd_sel,
    input  logic        ex_br_taken,
    input  logic        mem_valid,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        stall_ex_mem,
    output logic        stall_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        flush_mem_wb,
    output logic        mem_err,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    localparam logic [1:0] WdSelLoad  = 2'b01;
    localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StErr
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] wait_inc;

    logic       mem_stall;
    logic       dmem_req_raw;
    logic       branch_hit;
    logic       load_use_hit;
    logic       src0_match;
    logic       src1_match;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------

    // A zero register index means "no operand", so it never creates a dependency.
    always_comb begin
        src0_match   = (id_rf_ra0 != 5'd0) && (id_rf_ra0 == ex_rf_wa);
        src1_match   = (id_rf_ra1 != 5'd0) && (id_rf_ra1 == ex_rf_wa);
        load_use_hit = ex_rf_we && (ex_rf_wd_sel == WdSelLoad) && (ex_rf_wa != 5'd0)
                       && (src0_match || src1_match);
        branch_hit   = ex_br_taken;
    end

    // ------------------------------------------------------------------
    // Memory-wait FSM
    // ------------------------------------------------------------------

    // State and timeout counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic; also decides whether the memory stall applies this cycle.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        wait_inc     = wait_cnt_q + 8'd1;
        mem_stall    = 1'b0;
        dmem_req_raw = 1'b0;
        unique case (state_q)
            StIdle: begin
                dmem_req_raw = mem_valid;
                // An access acknowledged in its first cycle costs nothing.
                if (mem_valid && !dmem_ack) begin
                    mem_stall  = 1'b1;
                    state_d    = StWait;
                    wait_cnt_d = 8'd0;
                end
            end
            StWait: begin
                dmem_req_raw = 1'b1;
                if (dmem_ack) begin
                    // Ack cycle: let the pipeline advance right away.
                    state_d = StIdle;
                end else begin
                    mem_stall  = 1'b1;
                    wait_cnt_d = wait_inc;
                    if (wait_inc == TimeoutCnt) begin
                        state_d = StErr;
                    end
                end
            end
            StErr: begin
                // Freeze the pipeline until reset; no further memory requests.
                mem_stall = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stall / flush outputs
    // ------------------------------------------------------------------

    // Priority: memory stall > branch > load-use; everything idle while in reset.
    always_comb begin
        dmem_req     = dmem_req_raw && !rst;
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        stall_mem_wb = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        flush_mem_wb = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                // Hold everything up to EX/MEM; MEM/WB gets a bubble so the
                // stalled access is not written back repeatedly.
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                stall_ex_mem = 1'b1;
                flush_mem_wb = 1'b1;
            end else if (branch_hit) begin
                // Squash the two wrong-path instructions behind the branch.
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use_hit) begin
                // Hold the consumer in ID for one cycle, bubble into EX.
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
        end
    end

    // Error flag follows the terminal state, so it stays set until reset.
    always_comb begin
        mem_err = (state_q == StErr);
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    // Free-running event counters; wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            if (stall_pc) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            // flush_if_id is raised only by a taken branch that won priority.
            if (flush_if_id) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. A behavioural reference model
// (pending-access flag, elapsed wait count, error flag, event tallies) predicts
// every output; one process compares on each falling edge, and directed
// literal checks pin the key scenarios.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TIMEOUT = 4;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [4:0]  id_rf_ra0, id_rf_ra1, ex_rf_wa;
    logic        ex_rf_we, ex_br_taken, mem_valid, dmem_ack;
    logic [1:0]  ex_rf_wd_sel;
    logic        dmem_req, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic        flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, mem_err;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit done    = 1'b0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rf_ra0      (id_rf_ra0),
        .id_rf_ra1      (id_rf_ra1),
        .ex_rf_we       (ex_rf_we),
        .ex_rf_wa       (ex_rf_wa),
        .ex_rf_wd_sel   (ex_rf_wd_sel),
        .ex_br_taken    (ex_br_taken),
        .mem_valid      (mem_valid),
        .dmem_ack       (dmem_ack),
        .dmem_req       (dmem_req),
        .stall_pc       (stall_pc),
        .stall_if_id    (stall_if_id),
        .stall_id_ex    (stall_id_ex),
        .stall_ex_mem   (stall_ex_mem),
        .stall_mem_wb   (stall_mem_wb),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex),
        .flush_ex_mem   (flush_ex_mem),
        .flush_mem_wb   (flush_mem_wb),
        .mem_err        (mem_err),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle, bit 10 down to 0:
    // dmem_req, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
    // flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, mem_err
    logic [10:0] act;
    assign act = {dmem_req, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
                  flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb, mem_err};

    // ---------------- reference model ----------------
    bit          m_waiting = 1'b0;
    bit          m_err     = 1'b0;
    int unsigned m_waits   = 0;
    logic [31:0] m_stall   = '0;
    logic [31:0] m_flush   = '0;
    logic [10:0] exp_now;
    logic        m_hold, m_lu;

    always_comb begin
        exp_now = '0;
        m_hold  = m_err || (m_waiting && !dmem_ack) || (!m_waiting && mem_valid && !dmem_ack);
        m_lu    = ex_rf_we && (ex_rf_wd_sel == 2'b01) && (ex_rf_wa != 5'd0)
                  && ((id_rf_ra0 == ex_rf_wa) || (id_rf_ra1 == ex_rf_wa));
        if (!rst) begin
            exp_now[10] = !m_err && (m_waiting || mem_valid);
            exp_now[0]  = m_err;
            if (m_hold) begin
                exp_now[9:6] = 4'b1111;
                exp_now[1]   = 1'b1;
            end else if (ex_br_taken) begin
                exp_now[4] = 1'b1;
                exp_now[3] = 1'b1;
            end else if (m_lu) begin
                exp_now[9] = 1'b1;
                exp_now[8] = 1'b1;
                exp_now[3] = 1'b1;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_waiting <= 1'b0;
            m_err     <= 1'b0;
            m_waits   <= 0;
            m_stall   <= '0;
            m_flush   <= '0;
        end else begin
            m_stall <= m_stall + 32'(exp_now[9]);
            m_flush <= m_flush + 32'(exp_now[4]);
            if (!m_err) begin
                if (m_waiting) begin
                    if (dmem_ack) begin
                        m_waiting <= 1'b0;
                    end else begin
                        m_waits <= m_waits + 1;
                        if (m_waits + 1 == TIMEOUT) begin
                            m_err     <= 1'b1;
                            m_waiting <= 1'b0;
                        end
                    end
                end else if (mem_valid && !dmem_ack) begin
                    m_waiting <= 1'b1;
                    m_waits   <= 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, a, e);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!done) begin
            check("cycle_outputs", 32'(act), 32'(exp_now));
            check("cycle_perf_stall", perf_stall_cnt, PERF ? m_stall : 32'd0);
            check("cycle_perf_flush", perf_flush_cnt, PERF ? m_flush : 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic [4:0] ra0, input logic [4:0] ra1, input logic we,
                          input logic [4:0] wa, input logic [1:0] sel, input logic br,
                          input logic mv, input logic ack);
        id_rf_ra0    = ra0;
        id_rf_ra1    = ra1;
        ex_rf_we     = we;
        ex_rf_wa     = wa;
        ex_rf_wd_sel = sel;
        ex_br_taken  = br;
        mem_valid    = mv;
        dmem_ack     = ack;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 2'b00, 0, 0, 0);
        #2;
        check("reset_outputs", 32'(act), 32'd0);
        check("reset_perf_stall", perf_stall_cnt, 32'd0);
        tick();
        rst = 1'b0;
        #1 check("idle_all_zero", 32'(act), 32'd0);
        tick();

        // Load to x5 consumed via ra1: one-cycle load-use stall.
        set_in(0, 5, 1, 5, 2'b01, 0, 0, 0);
        #1 check("lu_ra1_pattern", 32'(act), 32'h308);
        tick();
        set_in(0, 0, 0, 0, 2'b00, 0, 0, 0);
        #1 check("lu_one_cycle_only", 32'(stall_pc), 32'd0);
        tick();

        // Same hazard via ra0.
        set_in(7, 0, 1, 7, 2'b01, 0, 0, 0);
        #1 check("lu_ra0_stall_pc", 32'(stall_pc), 32'd1);
        tick();

        // Load-use plus branch: branch wins.
        set_in(0, 5, 1, 5, 2'b01, 1, 0, 0);
        #1 check("br_over_lu", 32'(act), 32'h018);
        tick();
        check("perf_flush_after_br", perf_flush_cnt, PERF ? 32'd1 : 32'd0);
        check("perf_stall_after_lu", perf_stall_cnt, PERF ? 32'd2 : 32'd0);

        // Load to x0 with ra0 = 0: no hazard.
        set_in(0, 0, 1, 0, 2'b01, 0, 0, 0);
        #1 check("lu_x0_none", 32'(act), 32'd0);
        tick();

        // ALU result (not a load) with a matching source: no stall.
        set_in(0, 9, 1, 9, 2'b00, 0, 0, 0);
        #1 check("alu_no_stall", 32'(act), 32'd0);
        tick();

        // Access acknowledged in its first cycle: request only.
        set_in(0, 0, 0, 0, 2'b00, 0, 1, 1);
        #1 check("mem_fast_ack", 32'(act), 32'h400);
        tick();

        // Ack three cycles after the request: three stall cycles.
        set_in(0, 0, 0, 0, 2'b00, 0, 1, 0);
        #1 check("mem_stall_c0", 32'(act), 32'h7C2);
        tick();
        set_in(0, 0, 0, 0, 2'b00, 1, 1, 0);
        #1 check("mem_over_branch", 32'(act), 32'h7C2);
        tick();
        set_in(0, 0, 0, 0, 2'b00, 0, 1, 0);
        tick();
        set_in(0, 0, 0, 0, 2'b00, 0, 1, 1);
        #1 check("mem_ack_cycle", 32'(act), 32'h400);
        tick();
        set_in(0, 0, 0, 0, 2'b00, 0, 0, 0);
        #1 check("mem_back_idle", 32'(act), 32'd0);
        check("perf_stall_after_mem", perf_stall_cnt, PERF ? 32'd5 : 32'd0);
        check("perf_flush_after_mem", perf_flush_cnt, PERF ? 32'd1 : 32'd0);
        tick();

        // No ack ever: timeout into the error state after TIMEOUT wait cycles.
        set_in(0, 0, 0, 0, 2'b00, 0, 1, 0);
        tick();
        tick();
        tick();
        tick();
        #1 check("timeout_last_wait", 32'(act), 32'h7C2);
        tick();
        #1 check("err_entered", 32'(act), 32'h3C3);
        set_in(0, 0, 0, 0, 2'b00, 0, 0, 0);
        tick();
        #1 check("err_sticky", 32'(act), 32'h3C3);
        #1 rst = 1'b1;
        #1 check("err_async_rst", 32'(act), 32'd0);
        check("rst_perf_stall", perf_stall_cnt, 32'd0);
        check("rst_perf_flush", perf_flush_cnt, 32'd0);
        tick();
        rst = 1'b0;
        #1 check("after_err_rst", 32'(act), 32'd0);
        tick();

        // Reset pulse in the middle of a wait, with the access still pending.
        set_in(0, 0, 0, 0, 2'b00, 0, 1, 0);
        tick();
        #2 rst = 1'b1;
        #1 check("wait_async_rst", 32'(act), 32'd0);
        tick();
        set_in(0, 0, 0, 0, 2'b00, 0, 0, 0);
        rst = 1'b0;
        #1 check("wait_rst_idle", 32'(act), 32'd0);
        tick();
        tick();

        done = 1'b1;
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
